// File: rtl/fp16_divider.sv
// fp16_divider: iterative IEEE-754 binary16 divider, out = a / b, round-to-nearest-even.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only while idle)
//   a, b                dividend / divisor, fp16
//   out_valid/out_ready result handshake; out held until accepted
//   out                 quotient, fp16 (registered)
module fp16_divider #(
  parameter logic [15:0] QNAN = 16'h7e00,
  parameter int          ITER = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
  state_t             state_q;
  logic               s_q;
  logic signed [6:0]  e_q;
  logic [10:0]        mb_q;
  logic [11:0]        rem_q;
  logic [13:0]        q_q;
  logic [3:0]         cnt_q;
  logic [15:0]        out_q;
  logic               out_valid_q;
  logic [4:0]         ea, eb;
  logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic               s_in, spec_nan, spec_inf, spec_zero, special;
  logic [15:0]        spec_out;
  logic signed [6:0]  e_in;
  logic               ge;
  logic [11:0]        rem_sub, rem_d;
  logic [13:0]        q_d;
  logic               hi, g, st, up;
  logic [9:0]         frac_r;
  logic [10:0]        frac_sum;
  logic signed [6:0]  e_n, e_r;
  logic [15:0]        round_out;
  assign ea        = a[14:10];
  assign eb        = b[14:10];
  // subnormals (exponent 0) are flushed to zero
  assign a_zero    = ea == 5'd0;
  assign b_zero    = eb == 5'd0;
  assign a_inf     = (&ea) & ~(|a[9:0]);
  assign b_inf     = (&eb) & ~(|b[9:0]);
  assign a_nan     = (&ea) & (|a[9:0]);
  assign b_nan     = (&eb) & (|b[9:0]);
  assign s_in      = a[15] ^ b[15];
  assign spec_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign spec_inf  = a_inf | b_zero;
  assign spec_zero = a_zero | b_inf;
  assign special   = spec_nan | spec_inf | spec_zero;
  assign spec_out  = spec_nan ? QNAN : spec_inf ? {s_in, 15'h7c00} : {s_in, 15'h0000};
  assign e_in      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
  // restoring step: remainder stays below 2*mb, so 12 bits never overflow
  assign ge        = rem_q >= {1'b0, mb_q};
  assign rem_sub   = ge ? rem_q - {1'b0, mb_q} : rem_q;
  assign rem_d     = rem_sub << 1;
  assign q_d       = {q_q[12:0], ge};
  // quotient lies in [0.5, 2); the hidden bit is q[13] or q[12], so only the fraction is kept
  assign hi        = q_q[13];
  assign frac_r    = hi ? q_q[12:3] : q_q[11:2];
  assign g         = hi ? q_q[2] : q_q[1];
  assign st        = (hi ? |q_q[1:0] : q_q[0]) | (|rem_q);
  assign e_n       = hi ? e_q : e_q - 7'sd1;
  assign up        = g & (st | frac_r[0]);
  assign frac_sum  = {1'b0, frac_r} + {10'd0, up};
  // a carry out of the fraction leaves it zero, which is exactly 1.0 at the next exponent
  assign e_r       = frac_sum[10] ? e_n + 7'sd1 : e_n;
  assign round_out = (e_r >= 7'sd31) ? {s_q, 15'h7c00} :
                     (e_r <= 7'sd0)  ? {s_q, 15'h0000} : {s_q, e_r[4:0], frac_sum[9:0]};
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e_q         <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          s_q <= s_in;
          if (special) begin
            out_q       <= spec_out;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            e_q     <= e_in;
            mb_q    <= {1'b1, b[9:0]};
            rem_q   <= {2'b01, a[9:0]};
            q_q     <= '0;
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(ITER - 1)) state_q <= ROUND;
        end
        ROUND: begin
          out_q       <= round_out;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
